vdp_copper: RTL and testbench



---
 rtl/vdp_copper_defs.sv | 19 +
 rtl/vdp_copper.sv | 111 +++++++++++
 tb/tb_vdp_copper.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/vdp_copper_defs.sv
// vdp_copper_defs: opcodes, FSM states and command field positions shared by the copper.
package vdp_copper_defs;
    localparam logic [1:0] COP_OP_WAIT_Y = 2'b00;
    localparam logic [1:0] COP_OP_WAIT_X = 2'b01;
    localparam logic [1:0] COP_OP_WRITE  = 2'b10;
    localparam logic [1:0] COP_OP_HALT   = 2'b11;
    localparam int OP_HI       = 15;
    localparam int OP_LO       = 14;
    localparam int CNT_HI      = 12;
    localparam int CNT_LO      = 8;
    localparam int AUTOINC_BIT = 7;
    localparam int REG_HI      = 4;
    localparam int REG_LO      = 0;
    localparam int WAIT_Y_HI   = 9;
    localparam int WAIT_X_HI   = 10;
    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_WAIT_Y, ST_WAIT_X, ST_DATA_FETCH, ST_DATA_ISSUE, ST_HALTED
    } cop_state_e;
endpackage

// File: rtl/vdp_copper.sv
// vdp_copper: raster-synchronised command processor that fetches a per-frame list from
// copper RAM and issues timed VDP register writes.
module vdp_copper
    import vdp_copper_defs::*;
#(
    parameter int RAM_ADDRESS_WIDTH = 11,
    parameter int RASTER_X_WIDTH    = 11,
    parameter int RASTER_Y_WIDTH    = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         frame_start,
    input  logic [RASTER_X_WIDTH-1:0]    raster_x,
    input  logic [RASTER_Y_WIDTH-1:0]    raster_y,
    output logic [RAM_ADDRESS_WIDTH-1:0] ram_read_address,
    input  logic [15:0]                  ram_read_data,
    output logic                         cop_write_en,
    output logic [4:0]                   cop_write_address,
    output logic [15:0]                  cop_write_data,
    output logic                         halted
);
    cop_state_e state_q, state_d;
    logic [RAM_ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [4:0]  cnt_q, cnt_d, addr_q, addr_d, wa_q, wa_d;
    logic        inc_q, inc_d, we_q, we_d, halted_q, halted_d;
    logic [10:0] wait_q, wait_d;
    logic [15:0] wd_q, wd_d;
    logic [1:0]  op;
    logic        x_ok, y_ok, unused_bit;

    assign op = ram_read_data[OP_HI:OP_LO];
    assign unused_bit = ram_read_data[13];
    // The wait operand is latched at decode because the RAM output moves on once pc advances.
    assign x_ok = 32'(raster_x) >= 32'(wait_q);
    assign y_ok = 32'(raster_y) >= 32'(wait_q);
    assign ram_read_address  = pc_q;
    assign cop_write_en      = we_q;
    assign cop_write_address = wa_q;
    assign cop_write_data    = wd_q;
    assign halted            = halted_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        inc_d    = inc_q;
        wait_d   = wait_q;
        we_d     = state_q == ST_DATA_ISSUE;
        wa_d     = we_d ? addr_q : wa_q;
        wd_d     = we_d ? ram_read_data : wd_q;
        halted_d = state_q == ST_IDLE || state_q == ST_HALTED;
        case (state_q)
            ST_FETCH:      state_d = ST_DECODE;
            ST_DECODE: begin
                pc_d    = pc_q + 1'b1;
                cnt_d   = ram_read_data[CNT_HI:CNT_LO];
                addr_d  = ram_read_data[REG_HI:REG_LO];
                inc_d   = ram_read_data[AUTOINC_BIT];
                wait_d  = op == COP_OP_WAIT_Y ? {1'b0, ram_read_data[WAIT_Y_HI:0]} : ram_read_data[WAIT_X_HI:0];
                state_d = op == COP_OP_HALT ? ST_HALTED : op == COP_OP_WRITE ? ST_DATA_FETCH :
                          op == COP_OP_WAIT_X ? ST_WAIT_X : ST_WAIT_Y;
            end
            ST_WAIT_Y:     state_d = y_ok ? ST_FETCH : ST_WAIT_Y;
            ST_WAIT_X:     state_d = x_ok ? ST_FETCH : ST_WAIT_X;
            ST_DATA_FETCH: state_d = ST_DATA_ISSUE;
            ST_DATA_ISSUE: begin
                pc_d    = pc_q + 1'b1;
                addr_d  = inc_q ? addr_q + 5'd1 : addr_q;
                cnt_d   = cnt_q == 5'd0 ? cnt_q : cnt_q - 5'd1;
                state_d = cnt_q == 5'd0 ? ST_FETCH : ST_DATA_FETCH;
            end
            default:       state_d = state_q;
        endcase
        if (frame_start) begin
            pc_d    = '0;
            state_d = ST_FETCH;
        end
        if (!enable) begin
            pc_d    = pc_q;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            inc_q    <= 1'b0;
            wait_q   <= '0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            halted_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            inc_q    <= inc_d;
            wait_q   <= wait_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            halted_q <= halted_d;
        end
    end
endmodule

// File: tb/tb_vdp_copper.sv
// tb_vdp_copper: table-driven frames, corner-case sequences and random command lists
// checked cycle by cycle against a command-level timing model of the copper.
module tb_vdp_copper;
    localparam int MAXC  = 8000;
    localparam int NEVER = 1 << 30;

    logic        clk, reset, enable, frame_start;
    logic [10:0] raster_x, ram_read_address;
    logic [9:0]  raster_y;
    logic [15:0] ram_read_data, cop_write_data;
    logic        cop_write_en, halted;
    logic [4:0]  cop_write_address;

    logic [15:0] mem [2048];
    bit          exp_en [MAXC];
    logic [4:0]  exp_a [MAXC];
    logic [15:0] exp_d [MAXC];
    int          xper, tests, fails;

    typedef struct {
        logic [0:5][15:0] prog;
        int               xper;
        int               nw;
        logic [0:2][31:0] wc;
        logic [0:2][4:0]  wa;
        logic [0:2][15:0] wd;
        int               hc;
    } vec_t;
    vec_t vecs [4];

    vdp_copper dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
        .raster_x(raster_x), .raster_y(raster_y), .ram_read_address(ram_read_address),
        .ram_read_data(ram_read_data), .cop_write_en(cop_write_en),
        .cop_write_address(cop_write_address), .cop_write_data(cop_write_data), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) ram_read_data <= mem[ram_read_address];

    function automatic logic [10:0] rx(input int c);
        return 11'((c % xper) * 4);
    endfunction

    function automatic logic [9:0] ry(input int c);
        return 10'(c / xper);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic clear_exp();
        for (int c = 0; c < MAXC; c++) exp_en[c] = 1'b0;
    endtask

    // Interprets the list in mem as commands with the documented timing: fetch at t,
    // strobes of a burst at t+4+2k, next fetch after a satisfied wait at w+1.
    task automatic model_frame(output int hc);
        int t, pc, w, n;
        logic [15:0] c;
        logic [4:0] a;
        clear_exp();
        t = 1; pc = 0; hc = -1;
        while (t < MAXC && hc < 0) begin
            c = mem[pc];
            pc = (pc + 1) % 2048;
            if (c[15:14] == 2'b11) hc = t + 3;
            else if (c[15] == 1'b0) begin
                w = t + 2;
                while (w < MAXC && (c[14] ? int'(rx(w)) < int'(c[10:0]) : int'(ry(w)) < int'(c[9:0]))) w++;
                t = w + 1;
            end else begin
                n = int'(c[12:8]) + 1;
                a = c[4:0];
                for (int k = 0; k < n; k++) begin
                    if (t + 4 + 2 * k < MAXC) begin
                        exp_en[t + 4 + 2 * k] = 1'b1;
                        exp_a[t + 4 + 2 * k] = a;
                        exp_d[t + 4 + 2 * k] = mem[pc];
                    end
                    pc = (pc + 1) % 2048;
                    if (c[7]) a = a + 5'd1;
                end
                t += 2 + 2 * n;
            end
        end
    endtask

    task automatic run_frame(input int ncyc, input int hc, input int fs2, input int en_off, input int en_on);
        for (int c = 0; c <= ncyc; c++) begin
            @(posedge clk); #1;
            frame_start = (c == 0 || c == fs2);
            enable = !(c >= en_off && c < en_on);
            raster_x = rx(c);
            raster_y = ry(c);
            if (c > 0) begin
                chk("write_en", cop_write_en, exp_en[c]);
                if (exp_en[c]) begin
                    chk("write_addr", cop_write_address, exp_a[c]);
                    chk("write_data", cop_write_data, exp_d[c]);
                end
                if (c == hc) chk("halted_set", halted, 1);
                if (c == hc - 1) chk("halted_clear", halted, 0);
                if (c == fs2 + 1) chk("pc_restart", ram_read_address, 0);
                if (c == en_off + 2) chk("halted_idle", halted, 1);
            end
        end
    endtask

    initial begin
        int hc, pc, n;
        tests = 0; fails = 0; xper = 10;
        for (int i = 0; i < 2048; i++) mem[i] = 16'hC000;
        reset = 1'b1; enable = 1'b0; frame_start = 1'b0; raster_x = '0; raster_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", cop_write_en, 0);
        chk("rst_addr", cop_write_address, 0);
        chk("rst_data", cop_write_data, 0);
        chk("rst_halted", halted, 1);
        chk("rst_pc", ram_read_address, 0);
        reset = 1'b0; enable = 1'b1;

        vecs[0] = '{{16'h8005, 16'hBEEF, 16'hC000, 16'hC000, 16'hC000, 16'hC000}, 10, 1,
                    {32'd5, 32'd0, 32'd0}, {5'd5, 5'd0, 5'd0}, {16'hBEEF, 16'h0, 16'h0}, 8};
        vecs[1] = '{{16'h829E, 16'h0001, 16'h0002, 16'h0003, 16'hC000, 16'hC000}, 10, 3,
                    {32'd5, 32'd7, 32'd9}, {5'd30, 5'd31, 5'd0}, {16'h1, 16'h2, 16'h3}, 12};
        vecs[2] = '{{16'h821E, 16'h0001, 16'h0002, 16'h0003, 16'hC000, 16'hC000}, 10, 3,
                    {32'd5, 32'd7, 32'd9}, {5'd30, 5'd30, 5'd30}, {16'h1, 16'h2, 16'h3}, 12};
        vecs[3] = '{{16'h0064, 16'h40C8, 16'h8002, 16'h1234, 16'hC000, 16'hC000}, 64, 1,
                    {32'd6455, 32'd0, 32'd0}, {5'd2, 5'd0, 5'd0}, {16'h1234, 16'h0, 16'h0}, 6458};
        for (int i = 0; i < 4; i++) begin
            xper = vecs[i].xper;
            for (int k = 0; k < 6; k++) mem[k] = vecs[i].prog[k];
            clear_exp();
            for (int k = 0; k < vecs[i].nw; k++) begin
                exp_en[int'(vecs[i].wc[k])] = 1'b1;
                exp_a[int'(vecs[i].wc[k])] = vecs[i].wa[k];
                exp_d[int'(vecs[i].wc[k])] = vecs[i].wd[k];
            end
            run_frame(vecs[i].hc + 2, vecs[i].hc, -1, NEVER, NEVER);
        end

        // second frame_start lands in the DATA_FETCH of burst word 2
        xper = 10;
        mem[0] = 16'h830A; mem[1] = 16'hA001; mem[2] = 16'hA002; mem[3] = 16'hA003; mem[4] = 16'hA004; mem[5] = 16'hC000;
        clear_exp();
        exp_en[5] = 1'b1; exp_a[5] = 5'd10; exp_d[5] = 16'hA001;
        for (int k = 0; k < 4; k++) begin
            exp_en[10 + 2 * k] = 1'b1; exp_a[10 + 2 * k] = 5'd10; exp_d[10 + 2 * k] = 16'hA001 + 16'(k);
        end
        run_frame(21, 19, 5, NEVER, NEVER);

        // enable dropped during WAIT_Y, raised again, list restarts on the next frame_start
        mem[0] = 16'h0003; mem[1] = 16'h8003; mem[2] = 16'h5555; mem[3] = 16'hC000;
        clear_exp();
        exp_en[48] = 1'b1; exp_a[48] = 5'd3; exp_d[48] = 16'h5555;
        run_frame(53, 51, 40, 10, 20);

        // WRITE at word 2047 takes its data from word 0 after pc wraps
        xper = 1;
        mem[0] = 16'h0005;
        for (int i = 1; i < 2047; i++) mem[i] = 16'h0000;
        mem[2047] = 16'h8007;
        model_frame(hc);
        run_frame(6152, -1, -1, NEVER, NEVER);

        for (int f = 0; f < 20; f++) begin
            xper = $urandom_range(8, 40);
            pc = 0;
            for (int k = 0; k < 6; k++) begin
                case ($urandom_range(0, 2))
                    0: begin mem[pc] = {6'b0, 10'($urandom_range(0, 20))}; pc++; end
                    1: begin mem[pc] = {5'b01000, 11'($urandom_range(0, (xper - 1) * 4))}; pc++; end
                    default: begin
                        n = $urandom_range(1, 4);
                        mem[pc] = {2'b10, 1'b0, 5'(n - 1), 1'($urandom), 2'($urandom), 5'($urandom)};
                        pc++;
                        for (int j = 0; j < n; j++) begin mem[pc] = 16'($urandom); pc++; end
                    end
                endcase
            end
            mem[pc] = 16'hC000;
            model_frame(hc);
            if (hc < 0) hc = MAXC - 3;
            run_frame(hc + 2, hc, -1, NEVER, NEVER);
        end

        // reset asserted in the middle of a burst
        xper = 10;
        mem[0] = 16'h829E; mem[1] = 16'h0001; mem[2] = 16'h0002; mem[3] = 16'h0003; mem[4] = 16'hC000;
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_en", cop_write_en, 0);
        chk("midrst_addr", cop_write_address, 0);
        chk("midrst_data", cop_write_data, 0);
        chk("midrst_halted", halted, 1);
        chk("midrst_pc", ram_read_address, 0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
